// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings, FSM state type and size helpers for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_align_mask(input logic [2:0] size);
    case (size)
      HSIZE_BYTE: return 3'b000;
      HSIZE_HALF: return 3'b001;
      HSIZE_WORD: return 3'b011;
      default:    return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side signal bundle for the SRAM scratchpad.
interface ahb_sram_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic                  HREADYin;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYout;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADYin, HWDATA,
    input  HRDATA, HREADYout, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADYin, HWDATA,
    output HRDATA, HREADYout, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave_bank.sv
// Byte-enabled register array: one clocked write port, one asynchronous read port.
module ahb_sram_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 16,
  localparam int AW        = $clog2(MEM_WORDS),
  localparam int NBYTES    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [NBYTES-1:0]     wstrb_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Array is deliberately not reset; contents survive HRESETn.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address-phase decode, legality checks, data-phase FSM.
//   state | meaning
//   IDLE  | no data phase pending
//   WDATA | write data phase, commits at its closing edge
//   RWAIT | read wait state, word captured (READ_WAIT=1 only)
//   RDATA | read data phase, HRDATA valid
//   ERR1  | first ERROR cycle, HREADYout low
//   ERR2  | second ERROR cycle, HREADYout high
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 16,
  parameter int READ_WAIT  = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_sram_slave_if.slave  bus
);

  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);
  localparam int AW       = $clog2(MEM_WORDS);

  state_t                state_q;
  logic                  hready_q;
  logic                  hresp_q;
  logic [AW-1:0]         addr_q;
  logic [NBYTES-1:0]     strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept_d;
  logic                  legal_d;
  logic [AW-1:0]         addr_d;
  logic [NBYTES-1:0]     base_strb;
  logic [NBYTES-1:0]     strb_d;
  logic [DATA_WIDTH-1:0] bank_rdata;

  always_comb begin
    accept_d = bus.HSEL && bus.HREADYin &&
               (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
    addr_d   = bus.HADDR[ADDR_LSB +: AW];
    case (bus.HSIZE)
      HSIZE_BYTE: base_strb = NBYTES'(1);
      HSIZE_HALF: base_strb = NBYTES'(3);
      HSIZE_WORD: base_strb = NBYTES'(15);
      default:    base_strb = '1;
    endcase
    strb_d   = base_strb << bus.HADDR[ADDR_LSB-1:0];
    // Any set bit above the memory window is an out-of-range access.
    legal_d  = (bus.HSIZE <= 3'(ADDR_LSB)) &&
               ((bus.HADDR[2:0] & size_align_mask(bus.HSIZE)) == 3'b000) &&
               (bus.HADDR[31:ADDR_LSB+AW] == '0);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      addr_q   <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_RWAIT: begin
          state_q  <= ST_RDATA;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          rdata_q  <= bank_rdata;
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          // Final ready cycle of any data phase: the next address phase may land here.
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          if (accept_d) begin
            addr_q <= addr_d;
            strb_q <= strb_d;
            if (!legal_d) begin
              state_q  <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
            end else if (bus.HWRITE) begin
              state_q <= ST_WDATA;
            end else if (READ_WAIT != 0) begin
              state_q  <= ST_RWAIT;
              hready_q <= 1'b0;
            end else begin
              state_q <= ST_RDATA;
            end
          end
        end
      endcase
    end
  end

  ahb_sram_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_bank (
    .clk_i   (HCLK),
    .we_i    (state_q == ST_WDATA),
    .waddr_i (addr_q),
    .wstrb_i (strb_q),
    .wdata_i (bus.HWDATA),
    .raddr_i (addr_q),
    .rdata_o (bank_rdata)
  );

  assign bus.HREADYout = hready_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = (state_q != ST_RDATA) ? '0 :
                         (READ_WAIT != 0)      ? rdata_q : bank_rdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised bench for ahb_sram_slave: zero-wait and one-wait-read instances vs a byte-level model.
module tb_ahb_sram_slave;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        use_rw = 1'b0;
  logic        hsel   = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize  = 3'd0;
  logic [31:0] haddr  = 32'd0;
  logic [31:0] hwdata = 32'd0;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahb_sram_slave_if #(.DATA_WIDTH(32)) if0 ();
  ahb_sram_slave_if #(.DATA_WIDTH(32)) if1 ();

  assign if0.HSEL     = hsel & ~use_rw;
  assign if1.HSEL     = hsel & use_rw;
  assign if0.HADDR    = haddr;
  assign if1.HADDR    = haddr;
  assign if0.HWRITE   = hwrite;
  assign if1.HWRITE   = hwrite;
  assign if0.HSIZE    = hsize;
  assign if1.HSIZE    = hsize;
  assign if0.HTRANS   = htrans;
  assign if1.HTRANS   = htrans;
  assign if0.HWDATA   = hwdata;
  assign if1.HWDATA   = hwdata;
  assign if0.HREADYin = if0.HREADYout;
  assign if1.HREADYin = if1.HREADYout;

  assign hready = use_rw ? if1.HREADYout : if0.HREADYout;
  assign hresp  = use_rw ? if1.HRESP     : if0.HRESP;
  assign hrdata = use_rw ? if1.HRDATA    : if0.HRDATA;

  ahb_sram_slave #(.DATA_WIDTH(32), .MEM_WORDS(16), .READ_WAIT(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(if0.slave));
  ahb_sram_slave #(.DATA_WIDTH(32), .MEM_WORDS(16), .READ_WAIT(1)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .bus(if1.slave));

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    bit          active;
    bit          err;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } phase_t;

  // Reference memory per instance, one entry per byte address (16 words x 4 bytes).
  logic [7:0] mem_m [2][64];
  xfer_t      q[$];
  phase_t     ph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t, rw=%0d)", tag, obs, exp, $time, use_rw);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] size, input logic [31:0] addr);
    int unsigned nb;
    nb = 1 << size;
    return (size <= 3'd2) && ((addr % nb) == 0) && (addr < 64);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] addr);
    int unsigned b;
    b = (addr / 4) * 4;
    return {mem_m[d][b+3], mem_m[d][b+2], mem_m[d][b+1], mem_m[d][b]};
  endfunction

  task automatic push(input bit sel, input logic [1:0] trans, input bit write,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t t;
    t.sel = sel; t.trans = trans; t.write = write;
    t.size = size; t.addr = addr; t.wdata = wdata;
    q.push_back(t);
  endtask

  // Present one address phase (with the previous transfer's data phase) until it is accepted.
  task automatic run_xfer(input xfer_t t);
    int  k;
    int  d;
    bit  wait_c;
    bit  exp_rdy;
    d      = use_rw ? 1 : 0;
    hsel   = t.sel;
    htrans = t.trans;
    hwrite = t.write;
    hsize  = t.size;
    haddr  = t.addr;
    hwdata = ph.wdata;
    wait_c = ph.active && (ph.err || (!ph.write && use_rw));
    k = 0;
    forever begin
      @(negedge clk);
      exp_rdy = !(wait_c && k == 0);
      chk("hready", {31'd0, hready}, {31'd0, exp_rdy});
      chk("hresp", {31'd0, hresp}, {31'd0, ph.active && ph.err});
      if (exp_rdy) begin
        if (ph.active && !ph.err && !ph.write) chk("rdata", hrdata, ph.rexp);
        else chk("rdata_zero", hrdata, 32'd0);
      end
      if (hready) break;
      k++;
      if (k > 3) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    if (ph.active && !ph.err && ph.write) begin
      for (int i = 0; i < (1 << ph.size); i++) begin
        int unsigned a;
        a = ph.addr + i;
        mem_m[d][a] = ph.wdata[(a % 4) * 8 +: 8];
      end
    end
    ph.active = t.sel && t.trans[1];
    ph.err    = !is_legal(t.size, t.addr);
    ph.write  = t.write;
    ph.size   = t.size;
    ph.addr   = t.addr;
    ph.wdata  = t.wdata;
    ph.rexp   = (ph.active && !ph.err && !ph.write) ? model_word(d, t.addr) : 32'd0;
    #1;
  endtask

  task automatic run_all();
    xfer_t idle_t;
    idle_t.sel = 1'b0; idle_t.trans = 2'b00; idle_t.write = 1'b0;
    idle_t.size = 3'd0; idle_t.addr = 32'd0; idle_t.wdata = $urandom;
    while (q.size() > 0) run_xfer(q.pop_front());
    run_xfer(idle_t);
    run_xfer(idle_t);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      int          r;
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] a;
      r  = $urandom_range(0, 7);
      tr = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'($urandom_range(2, 3));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r  = $urandom_range(0, 15);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'($urandom_range(64, 127));
      else begin
        a = 32'($urandom_range(0, 63));
        if (sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      end
      push($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ph = '{default: '0};
    #12;
    use_rw = 1'b0; #1;
    chk("rst0_hready", {31'd0, hready}, 32'd1);
    chk("rst0_hresp", {31'd0, hresp}, 32'd0);
    chk("rst0_hrdata", hrdata, 32'd0);
    use_rw = 1'b1; #1;
    chk("rst1_hready", {31'd0, hready}, 32'd1);
    chk("rst1_hresp", {31'd0, hresp}, 32'd0);
    chk("rst1_hrdata", hrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill both memories so every later read has a defined expectation.
    for (int d = 0; d < 2; d++) begin
      use_rw = d[0];
      for (int w = 0; w < 16; w++) push(1, 2'b10, 1, 3'd2, 32'(w * 4), $urandom);
      run_all();
    end

    use_rw = 1'b0;
    push(1, 2'b10, 1, 3'd2, 32'h08, 32'hDEADBEEF);      // T1
    push(1, 2'b10, 0, 3'd2, 32'h08, 32'h0);
    push(1, 2'b10, 1, 3'd2, 32'h04, 32'h0);             // T2
    push(1, 2'b11, 1, 3'd0, 32'h05, 32'h0000AA00);
    push(1, 2'b11, 1, 3'd1, 32'h06, 32'h12340000);
    push(1, 2'b10, 0, 3'd2, 32'h04, 32'h0);
    push(1, 2'b10, 1, 3'd2, 32'h40, 32'hFFFFFFFF);      // T4
    push(1, 2'b10, 0, 3'd2, 32'h02, 32'h0);
    push(1, 2'b10, 0, 3'd2, 32'h00, 32'h0);
    push(1, 2'b10, 1, 3'd2, 32'h00, 32'hCAFEF00D);      // T5
    push(1, 2'b01, 0, 3'd2, 32'h00, 32'h0);
    push(1, 2'b00, 0, 3'd2, 32'h00, 32'h0);
    push(1, 2'b11, 0, 3'd2, 32'h00, 32'h0);
    push(0, 2'b10, 1, 3'd2, 32'h0C, 32'h55555555);
    push(1, 2'b10, 0, 3'd2, 32'h0C, 32'h0);
    run_all();
    chk("t2_word", model_word(0, 32'h04), 32'h1234AA00);

    use_rw = 1'b1;
    push(1, 2'b10, 1, 3'd2, 32'h08, 32'hDEADBEEF);      // T3
    push(0, 2'b00, 0, 3'd2, 32'h00, 32'h0);
    push(1, 2'b10, 0, 3'd2, 32'h08, 32'h0);
    push(1, 2'b10, 1, 3'd2, 32'h40, 32'h0);
    push(1, 2'b10, 0, 3'd2, 32'h08, 32'h0);
    run_all();

    for (int d = 0; d < 2; d++) begin
      use_rw = d[0];
      push_random(200);
      run_all();
    end

    // T6: reset asserted while the one-wait instance sits in its read wait state.
    use_rw = 1'b1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h08;
    @(posedge clk); #2;
    hsel = 1'b0; htrans = 2'b00;
    chk("t6_in_wait", {31'd0, hready}, 32'd0);
    rst_n = 1'b0; #1;
    chk("t6_rst_hready", {31'd0, hready}, 32'd1);
    chk("t6_rst_hresp", {31'd0, hresp}, 32'd0);
    chk("t6_rst_hrdata", hrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ph = '{default: '0};
    push(1, 2'b10, 0, 3'd2, 32'h08, 32'h0);
    push(1, 2'b10, 1, 3'd1, 32'h0A, 32'h77660000);
    push(1, 2'b10, 0, 3'd2, 32'h08, 32'h0);
    run_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
